overlay_rom_fetch: RTL

OVERLAY_ROM_FETCH -- requirements
Module: overlay_rom_fetch

---
 rtl/overlay_rom_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/overlay_rom_fetch.sv
// overlay_rom_fetch: sprite-window ROM address generator with a sync-aligned pixel output stage.
module overlay_rom_fetch #(
    parameter int unsigned ORIGIN_X    = 100,
    parameter int unsigned ORIGIN_Y    = 100,
    parameter int unsigned SPRITE_W    = 64,
    parameter int unsigned SPRITE_H    = 32,
    parameter int unsigned ROM_LATENCY = 2,
    parameter logic [7:0]  KEY         = 8'h00
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [11:0] pixelX,
    input  logic [11:0] pixelY,
    input  logic        videoActive,
    input  logic        hsyncIn,
    input  logic        vsyncIn,
    output logic [10:0] romAddress,
    input  logic [7:0]  romData,
    output logic [7:0]  overlayData,
    output logic        overlayValid,
    output logic        hsyncOut,
    output logic        vsyncOut,
    output logic        activeOut
);

    localparam int unsigned CW    = 12;
    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 8;
    localparam int unsigned LW    = 4;
    // The last delay stage lines up with romData for the address issued on the sampling edge;
    // the output registers then add the final cycle of latency.
    localparam int unsigned DEPTH = ROM_LATENCY + 1;
    localparam int unsigned LAST  = DEPTH - 1;

    // Lane positions inside one delay-line stage.
    localparam int unsigned L_WIN = 0;
    localparam int unsigned L_ACT = 1;
    localparam int unsigned L_VS  = 2;
    localparam int unsigned L_HS  = 3;

    localparam logic [CW-1:0] X_LO = CW'(ORIGIN_X);
    localparam logic [CW-1:0] X_HI = CW'(ORIGIN_X + SPRITE_W - 1);
    localparam logic [CW-1:0] Y_LO = CW'(ORIGIN_Y);
    localparam logic [CW-1:0] Y_HI = CW'(ORIGIN_Y + SPRITE_H - 1);

    logic          in_window_c;
    logic          vsync_rise_c;
    logic          win_delayed_c;

    logic          vsync_prev_q,  vsync_prev_d;
    logic [AW-1:0] addr_count_q,  addr_count_d;
    logic [AW-1:0] rom_address_q, rom_address_d;
    logic [LW-1:0] dly_q [DEPTH];
    logic [LW-1:0] dly_d [DEPTH];
    logic [DW-1:0] overlay_data_q, overlay_data_d;
    logic          overlay_valid_q, overlay_valid_d;
    logic          hsync_out_q, hsync_out_d;
    logic          vsync_out_q, vsync_out_d;
    logic          active_out_q, active_out_d;

    // Sprite window decode and vsync rising-edge detect on the sampled inputs.
    always_comb begin
        in_window_c  = videoActive
                    && (pixelX >= X_LO) && (pixelX <= X_HI)
                    && (pixelY >= Y_LO) && (pixelY <= Y_HI);
        vsync_rise_c = vsyncIn && !vsync_prev_q;
        vsync_prev_d = vsyncIn;
    end

    // Address counter: a frame start clears first, so a coincident in-window pixel fetches 0.
    always_comb begin
        addr_count_d  = addr_count_q;
        rom_address_d = rom_address_q;
        if (vsync_rise_c) begin
            addr_count_d = '0;
        end
        if (in_window_c) begin
            rom_address_d = addr_count_d;
            addr_count_d  = addr_count_d + AW'(1);
        end
    end

    // Delay line carrying syncs, active and window flag alongside the ROM access.
    always_comb begin
        dly_d[0] = {hsyncIn, vsyncIn, videoActive, in_window_c};
        for (int unsigned i = 1; i < DEPTH; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // Output stage: gate ROM data by the delayed window flag and apply the colour key.
    always_comb begin
        win_delayed_c   = dly_q[LAST][L_WIN];
        overlay_data_d  = win_delayed_c ? romData : '0;
        overlay_valid_d = win_delayed_c && (romData != KEY);
        hsync_out_d     = dly_q[LAST][L_HS];
        vsync_out_d     = dly_q[LAST][L_VS];
        active_out_d    = dly_q[LAST][L_ACT];
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_prev_q    <= 1'b0;
            addr_count_q    <= '0;
            rom_address_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dly_q[i] <= '0;
            end
            overlay_data_q  <= '0;
            overlay_valid_q <= 1'b0;
            hsync_out_q     <= 1'b0;
            vsync_out_q     <= 1'b0;
            active_out_q    <= 1'b0;
        end else begin
            vsync_prev_q    <= vsync_prev_d;
            addr_count_q    <= addr_count_d;
            rom_address_q   <= rom_address_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dly_q[i] <= dly_d[i];
            end
            overlay_data_q  <= overlay_data_d;
            overlay_valid_q <= overlay_valid_d;
            hsync_out_q     <= hsync_out_d;
            vsync_out_q     <= vsync_out_d;
            active_out_q    <= active_out_d;
        end
    end

    assign romAddress   = rom_address_q;
    assign overlayData  = overlay_data_q;
    assign overlayValid = overlay_valid_q;
    assign hsyncOut     = hsync_out_q;
    assign vsyncOut     = vsync_out_q;
    assign activeOut    = active_out_q;

endmodule
